// File: rtl/usb_rx_crc_ctrl.sv
// USB receive-side packet controller: captures the PID, steers the external
// CRC-5 / CRC-16 checkers over the packet body, checks body length, and
// reports a one-cycle completion pulse with held status flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for rcv_start
// PID   | shifting in the 8 PID bits (LSB first)
// BODY  | counting body bits, CRC enable asserted for the PID's class
// CHECK | one cycle: compare strobe to the checker, sample *_passed
// DONE  | one cycle: pkt_done, status valid
module usb_rx_crc_ctrl #(
  parameter int unsigned MAX_BITS = 8200
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcv_start,
  input  logic       bit_valid,
  input  logic       d_unstuffed,
  input  logic       eop,
  input  logic       crc_16_passed,
  input  logic       crc_5_passed,
  output logic       crc_init,
  output logic       crc_16_enable,
  output logic       crc_5_enable,
  output logic       crc_16_check,
  output logic       crc_5_check,
  output logic [3:0] pid,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       pid_err,
  output logic       crc_err,
  output logic       len_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_BODY,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [13:0] BODY_MAX = 14'(MAX_BITS);
  localparam logic [13:0] BODY_SAT = 14'(MAX_BITS + 1);

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [13:0] body_q, body_d;
  logic [3:0]  pid_q, pid_d;
  logic        pid_err_q, pid_err_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic        init_q, init_d;

  logic [7:0]  sr_next;
  logic        cls_tok, cls_dat, cls_hsk;
  logic        len_bad;

  function automatic logic is_tok(input logic [3:0] n);
    return (n == 4'b0001) || (n == 4'b1001) || (n == 4'b1101) || (n == 4'b0101);
  endfunction

  function automatic logic is_dat(input logic [3:0] n);
    return (n == 4'b0011) || (n == 4'b1011);
  endfunction

  function automatic logic is_hsk(input logic [3:0] n);
    return (n == 4'b0010) || (n == 4'b1010) || (n == 4'b1110);
  endfunction

  // Packet class and length rule derived from the captured PID.
  always_comb begin
    sr_next = {d_unstuffed, sr_q[7:1]};
    cls_tok = is_tok(pid_q);
    cls_dat = is_dat(pid_q);
    cls_hsk = is_hsk(pid_q);
    len_bad = (body_q > BODY_MAX) ||
              (!pid_err_q && ((cls_tok && (body_q != 14'd16)) ||
                              (cls_dat && ((body_q[2:0] != 3'd0) || (body_q < 14'd16))) ||
                              (cls_hsk && (body_q != 14'd0))));
  end

  // Next-state and register update logic; rcv_start restarts from any state.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    pcnt_d    = pcnt_q;
    body_d    = body_q;
    pid_d     = pid_q;
    pid_err_d = pid_err_q;
    crc_err_d = crc_err_q;
    len_err_d = len_err_q;
    pkt_ok_d  = pkt_ok_q;
    init_d    = 1'b0;

    if (rcv_start) begin
      state_d   = S_PID;
      init_d    = 1'b1;
      sr_d      = 8'd0;
      pcnt_d    = 3'd0;
      body_d    = 14'd0;
      pid_d     = 4'd0;
      pid_err_d = 1'b0;
      crc_err_d = 1'b0;
      len_err_d = 1'b0;
      pkt_ok_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_PID: begin
          // eop takes priority; a coincident bit is dropped
          if (eop) begin
            pid_err_d = 1'b1;
            pkt_ok_d  = 1'b0;
            state_d   = S_DONE;
          end else if (bit_valid) begin
            sr_d   = sr_next;
            pcnt_d = pcnt_q + 3'd1;
            if (pcnt_q == 3'd7) begin
              pid_d     = sr_next[3:0];
              pid_err_d = (sr_next[7:4] != ~sr_next[3:0]) ||
                          !(is_tok(sr_next[3:0]) || is_dat(sr_next[3:0]) ||
                            is_hsk(sr_next[3:0]));
              state_d   = S_BODY;
            end
          end
        end
        S_BODY: begin
          if (eop) begin
            state_d = S_CHECK;
          end else if (bit_valid && (body_q != BODY_SAT)) begin
            body_d = body_q + 14'd1;
          end
        end
        S_CHECK: begin
          crc_err_d = !pid_err_q && ((cls_dat && !crc_16_passed) ||
                                     (cls_tok && !crc_5_passed));
          len_err_d = len_bad;
          pkt_ok_d  = !(pid_err_q || crc_err_d || len_err_d);
          state_d   = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      sr_q      <= 8'd0;
      pcnt_q    <= 3'd0;
      body_q    <= 14'd0;
      pid_q     <= 4'd0;
      pid_err_q <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      pkt_ok_q  <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      pcnt_q    <= pcnt_d;
      body_q    <= body_d;
      pid_q     <= pid_d;
      pid_err_q <= pid_err_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      pkt_ok_q  <= pkt_ok_d;
      init_q    <= init_d;
    end
  end

  // Checker controls are decoded from state; a bad PID silences both checkers.
  always_comb begin
    crc_init      = init_q;
    crc_16_enable = (state_q == S_BODY)  && cls_dat && !pid_err_q;
    crc_5_enable  = (state_q == S_BODY)  && cls_tok && !pid_err_q;
    crc_16_check  = (state_q == S_CHECK) && cls_dat && !pid_err_q;
    crc_5_check   = (state_q == S_CHECK) && cls_tok && !pid_err_q;
    pkt_done      = (state_q == S_DONE);
    pid           = pid_q;
    pkt_ok        = pkt_ok_q;
    pid_err       = pid_err_q;
    crc_err       = crc_err_q;
    len_err       = len_err_q;
  end

endmodule

// File: tb/tb_usb_rx_crc_ctrl.sv
// Randomized bench for usb_rx_crc_ctrl; expected results come from the
// packet rules (PID class, complement check, body length, CRC verdict).
module tb_usb_rx_crc_ctrl;

  localparam int MAXB = 8200;

  logic       clk, n_rst, rcv_start, bit_valid, d_unstuffed, eop;
  logic       crc_16_passed, crc_5_passed;
  logic       crc_init, crc_16_enable, crc_5_enable, crc_16_check, crc_5_check;
  logic [3:0] pid;
  logic       pkt_done, pkt_ok, pid_err, crc_err, len_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_en16, exp_en5;
  int   en_bad, init_seen, chk16_seen, chk5_seen, done_seen;

  usb_rx_crc_ctrl #(.MAX_BITS(MAXB)) dut (
    .clk(clk), .n_rst(n_rst), .rcv_start(rcv_start), .bit_valid(bit_valid),
    .d_unstuffed(d_unstuffed), .eop(eop), .crc_16_passed(crc_16_passed),
    .crc_5_passed(crc_5_passed), .crc_init(crc_init), .crc_16_enable(crc_16_enable),
    .crc_5_enable(crc_5_enable), .crc_16_check(crc_16_check), .crc_5_check(crc_5_check),
    .pid(pid), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pid_err(pid_err),
    .crc_err(crc_err), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; observe outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (crc_16_enable !== exp_en16 || crc_5_enable !== exp_en5) en_bad++;
    if (crc_init)     init_seen++;
    if (crc_16_check) chk16_seen++;
    if (crc_5_check)  chk5_seen++;
    if (pkt_done)     done_seen++;
  endtask

  task automatic clear_counts();
    en_bad = 0; init_seen = 0; chk16_seen = 0; chk5_seen = 0; done_seen = 0;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      bit_valid   = 1'b0;
      d_unstuffed = 1'($urandom);
      step();
    end
  endtask

  task automatic drive_bit(input logic b);
    idle_gap();
    bit_valid   = 1'b1;
    d_unstuffed = b;
  endtask

  // early < 0: full packet; early >= 0: eop arrives with PID bit number early+1.
  task automatic send_pkt(input logic [7:0] pb, input int nbody, input int early,
                          input logic passed);
    logic [3:0] nib;
    logic tok, dat, hsk, perr, e_len, e_crc, e_ok;
    int npid;
    nib  = pb[3:0];
    tok  = nib inside {4'b0001, 4'b1001, 4'b1101, 4'b0101};
    dat  = nib inside {4'b0011, 4'b1011};
    hsk  = nib inside {4'b0010, 4'b1010, 4'b1110};
    perr = (early >= 0) || (pb[7:4] != ~nib) || !(tok || dat || hsk);
    if (early >= 0) e_len = 1'b0;
    else e_len = (nbody > MAXB) ||
                 (!perr && ((tok && nbody != 16) ||
                            (dat && ((nbody % 8) != 0 || nbody < 16)) ||
                            (hsk && nbody != 0)));
    e_crc = (early < 0) && !perr && (tok || dat) && !passed;
    e_ok  = !(perr || e_len || e_crc);

    exp_en16 = 1'b0; exp_en5 = 1'b0;
    clear_counts();
    rcv_start = 1'b1; bit_valid = 1'($urandom); eop = 1'b0;
    step();
    rcv_start = 1'b0; bit_valid = 1'b0;

    npid = (early >= 0) ? early : 8;
    for (int i = 0; i < npid; i++) begin
      drive_bit(pb[i]);
      if (i == 7) begin
        exp_en16 = dat && !perr;
        exp_en5  = tok && !perr;
      end
      step();
      bit_valid = 1'b0;
    end

    if (early >= 0) begin
      idle_gap();
      eop = 1'b1; bit_valid = 1'b1; d_unstuffed = 1'($urandom);
      step();
      eop = 1'b0; bit_valid = 1'b0;
      chk("done_early", pkt_done, 1'b1);
    end else begin
      for (int j = 0; j < nbody; j++) begin
        drive_bit(1'($urandom));
        step();
        bit_valid = 1'b0;
      end
      idle_gap();
      crc_16_passed = 1'($urandom); crc_5_passed = 1'($urandom);
      eop = 1'b1; bit_valid = 1'($urandom); d_unstuffed = 1'($urandom);
      exp_en16 = 1'b0; exp_en5 = 1'b0;
      step();
      eop = 1'b0; bit_valid = 1'($urandom);
      crc_16_passed = passed; crc_5_passed = passed;
      chk("check16", crc_16_check, dat && !perr);
      chk("check5", crc_5_check, tok && !perr);
      step();
      bit_valid = 1'b0;
      chk("done", pkt_done, 1'b1);
    end

    chk("pkt_ok", pkt_ok, e_ok);
    chk("pid_err", pid_err, perr);
    chk("crc_err", crc_err, e_crc);
    chk("len_err", len_err, e_len);
    chk("pid", pid, (early >= 0) ? 4'd0 : nib);
    step();
    chk("done_width", pkt_done, 1'b0);
    chk("ok_held", pkt_ok, e_ok);
    chk("init_cnt", init_seen, 1);
    chk("chk16_cnt", chk16_seen, (early < 0 && dat && !perr) ? 1 : 0);
    chk("chk5_cnt", chk5_seen, (early < 0 && tok && !perr) ? 1 : 0);
    chk("done_cnt", done_seen, 1);
    chk("enables", en_bad, 0);
  endtask

  // Start a DATA0 packet and stop after nbody body bits, leaving it in BODY.
  task automatic partial_data0(input int nbody);
    logic [7:0] pb;
    pb = 8'hC3;
    exp_en16 = 1'b0; exp_en5 = 1'b0;
    clear_counts();
    rcv_start = 1'b1;
    step();
    rcv_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(pb[i]);
      if (i == 7) exp_en16 = 1'b1;
      step();
      bit_valid = 1'b0;
    end
    for (int j = 0; j < nbody; j++) begin
      drive_bit(1'($urandom));
      step();
      bit_valid = 1'b0;
    end
  endtask

  logic [7:0] pid_tab [0:9];

  initial begin
    logic [7:0] pb;
    int nb, early;
    pid_tab = '{8'hE1, 8'h69, 8'h2D, 8'hA5, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'h33};

    n_rst = 1'b0; rcv_start = 1'b0; bit_valid = 1'b0; d_unstuffed = 1'b0; eop = 1'b0;
    crc_16_passed = 1'b0; crc_5_passed = 1'b0;
    exp_en16 = 1'b0; exp_en5 = 1'b0;
    clear_counts();
    step(); step();
    chk("reset_outs", {crc_init, crc_16_enable, crc_5_enable, crc_16_check, crc_5_check,
                       pkt_done, pkt_ok, pid_err, crc_err, len_err, pid}, 14'd0);
    n_rst = 1'b1;
    step();

    send_pkt(8'hC3, 32, -1, 1'b1);     // DATA0 good
    send_pkt(8'hC3, 32, -1, 1'b0);     // DATA0 corrupted
    send_pkt(8'hD2, 0, -1, 1'b1);      // ACK
    send_pkt(8'h33, 16, -1, 1'b1);     // non-complementary PID
    send_pkt(8'h4B, 20, -1, 1'b1);     // DATA1 bad length
    send_pkt(8'h4B, 0, 4, 1'b1);       // eop with 5th PID bit
    send_pkt(8'hE1, 16, -1, 1'b0);     // OUT token, bad CRC-5
    send_pkt(8'hE1, 17, -1, 1'b1);     // token wrong length
    send_pkt(8'hC3, 8, -1, 1'b1);      // data shorter than 16
    send_pkt(8'hC3, 8208, -1, 1'b1);   // data beyond MAX_BITS

    // abort in BODY after 10 bits, then a clean packet
    partial_data0(10);
    chk("abort_no_done", done_seen, 0);
    send_pkt(8'hC3, 24, -1, 1'b1);

    // reset mid-BODY
    partial_data0(12);
    exp_en16 = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_outs", {crc_init, crc_16_enable, crc_5_enable, crc_16_check, crc_5_check,
                         pkt_done, pkt_ok, pid_err, crc_err, len_err, pid}, 14'd0);
    step();
    n_rst = 1'b1;
    clear_counts();
    eop = 1'b1; step(); eop = 1'b0; step(); step();
    chk("rst_no_done", done_seen, 0);
    send_pkt(8'h5A, 0, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      pb = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pid_tab[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       nb = 16;
        1:       nb = 8 * $urandom_range(2, 6);
        2:       nb = 0;
        default: nb = $urandom_range(0, 40);
      endcase
      early = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1;
      send_pkt(pb, nb, early, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_crc_ctrl.md
USB_RX_CRC_CTRL -- requirements
Module: usb_rx_crc_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk rising-edge, n_rst active-low asynchronous.
REQ-002 Parameter: MAX_BITS, default 8200, maximum body bits (1023 data bytes + 16 CRC bits).
REQ-003 clk  input  1  system clock.
REQ-004 n_rst  input  1  async active-low reset.
REQ-005 rcv_start  input  1  one-cycle pulse, sync pattern detected, packet begins.
REQ-006 bit_valid  input  1  one-cycle strobe, d_unstuffed carries a valid unstuffed bit.
REQ-007 d_unstuffed  input  1  received bit, LSB first.
REQ-008 eop  input  1  one-cycle pulse, end of packet.
REQ-009 crc_16_passed  input  1  CRC-16 checker result, valid while crc_16_check=1.
REQ-010 crc_5_passed  input  1  CRC-5 checker result, valid while crc_5_check=1.
REQ-011 crc_init  output  1  clear both CRC checkers.
REQ-012 crc_16_enable  output  1  level; the checker gates it with bit_valid.
REQ-013 crc_5_enable  output  1  level; CRC-5 shift qualifier.
REQ-014 crc_16_check / crc_5_check  output  1 each  one-cycle compare strobes.
REQ-015 pid  output  4  captured PID nibble.
REQ-016 pkt_done  output  1  one-cycle completion pulse.
REQ-017 pkt_ok, pid_err, crc_err, len_err  output  1 each  status, held until next rcv_start.

Function
REQ-018 States SHALL be IDLE, PID, BODY, CHECK, DONE.
REQ-019 IDLE: on rcv_start, assert crc_init for exactly 1 cycle, clear the status outputs and the counters, and go to PID.
REQ-020 PID: shift 8 bits on bit_valid into an 8-bit register, LSB first, with a 3-bit count.
  - On the 8th bit, pid = bits[3:0].
  - pid_err=1 if bits[7:4] != ~bits[3:0].
  - Go to BODY.
REQ-021 PID classes:
  - token = 0001, 1001, 1101, 0101: CRC-5, body exactly 16 bits.
  - data = 0011, 1011: CRC-16, body a multiple of 8 bits and >= 16.
  - handshake = 0010, 1010, 1110: body 0 bits.
  - any other nibble: pid_err.
REQ-022 BODY: each bit_valid increments a 14-bit body counter that saturates at MAX_BITS+1.
  - crc_16_enable=1 only in BODY with a data PID.
  - crc_5_enable=1 only in BODY with a token PID.
  - Both enables SHALL be 0 in every other state.
REQ-023 The PID bits SHALL never be presented to either checker: both enables are 0 in PID.
REQ-024 On eop in BODY, go to CHECK.
REQ-025 CHECK lasts exactly 1 cycle.
  - Assert crc_16_check (data) or crc_5_check (token), and sample the matching *_passed in the same cycle.
  - Handshake: no check strobe.
REQ-026 crc_err=1 if the sampled *_passed=0.
REQ-027 len_err=1 if the count violates REQ-021 or exceeds MAX_BITS.
REQ-028 DONE lasts 1 cycle.
  - pkt_done=1.
  - pkt_ok = !(pid_err|crc_err|len_err).
  - Return to IDLE.
REQ-029 An eop in PID (fewer than 8 bits) SHALL set pid_err and go directly to DONE with no check strobe.
REQ-030 If bit_valid and eop arrive in the same cycle, eop SHALL win and that bit SHALL be discarded (not counted or shifted).
REQ-031 rcv_start in any non-IDLE state SHALL abort the current packet without a pkt_done, pulse crc_init, and restart in PID.
REQ-032 A pid_err packet SHALL suppress both CRC enables in BODY.
  - It still waits for eop.
  - It reports pkt_done with pkt_ok=0 and crc_err=0.
REQ-033 bit_valid in IDLE, CHECK or DONE SHALL be ignored.
REQ-034 Latency: pkt_done SHALL be asserted exactly 2 cycles after the eop cycle (CHECK, then DONE).

Reset
REQ-035 n_rst low SHALL force, asynchronously:
  - state IDLE;
  - all counters 0;
  - crc_init, enables, check strobes, pkt_done = 0;
  - pid = 4'b0000;
  - pkt_ok, pid_err, crc_err, len_err = 0.
REQ-036 Reset mid-packet SHALL discard the packet with no pkt_done; a following rcv_start SHALL behave as from power-up.

Verification
REQ-037 DATA0 PID 0xC3, 2 bytes 0x00 0x01 plus a correct CRC-16 (body 32 bits), eop -> crc_16_check pulse 1 cycle after eop, pkt_done 2 cycles after eop, pkt_ok=1, pid=0011.
REQ-038 Same packet with one corrupted payload bit, crc_16_passed=0 -> crc_err=1, pkt_ok=0, len_err=0.
REQ-039 ACK PID 0xD2 followed immediately by eop -> no check strobe, crc_16_enable never 1, pkt_done with pkt_ok=1, pid=0010.
REQ-040 PID byte 0x33 (nibbles not complementary) and 16 body bits -> pid_err=1, both enables stay 0, pkt_ok=0.
REQ-041 DATA1 with a 20-bit body, crc_16_passed=1 -> len_err=1, pkt_ok=0; eop coincident with the 5th PID bit_valid -> pid_err=1, pkt_done 1 cycle later.
REQ-042 rcv_start in BODY after 10 bits -> crc_init pulse, no pkt_done, next packet passes normally; n_rst low mid-BODY -> all outputs 0 immediately.
